// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - fetch/data master and external memory bus signals of mem_bus_arbiter
// master: arbiter view (drives bus and completions); slave: masters and memory view.
interface mem_bus_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_req;
  logic [3:0]  bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        err;

  modport master (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, bus_rdata, bus_ack,
    output i_rdata, i_ready, d_rdata, d_ready, bus_req, bus_wen, bus_addr, bus_wdata, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, bus_rdata, bus_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, bus_req, bus_wen, bus_addr, bus_wdata, err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter/sequencer for the shared data-memory bus
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master mb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic [3:0]  bus_wen_q, bus_wen_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] resp_q, resp_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        err_q, err_d;
  logic        pick_data;

`ifdef MEM_ARB_RR_EN
  // last_q = 1 when data was granted last; fetch wins the next contested grant.
  logic        last_q, last_d;
  assign pick_data = mb.d_req && (!mb.i_req || !last_q);
`else
  assign pick_data = mb.d_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_wen_d   = bus_wen_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    resp_d      = resp_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (mb.i_req || mb.d_req) begin
          owner_d   = pick_data;
          bus_req_d = 1'b1;
          cnt_d     = 16'd0;
          state_d   = BUSY;
`ifdef MEM_ARB_RR_EN
          last_d    = pick_data;
`endif
          if (pick_data) begin
            bus_wen_d   = mb.d_wen;
            bus_addr_d  = mb.d_addr;
            bus_wdata_d = mb.d_wdata;
          end else begin
            bus_wen_d   = 4'h0;
            bus_addr_d  = mb.i_addr;
            bus_wdata_d = 32'h0;
          end
        end
      end
      BUSY: begin
        if (mb.bus_ack) begin
          resp_d    = mb.bus_rdata;
          bus_req_d = 1'b0;
          i_ready_d = !owner_q;
          d_ready_d = owner_q;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          // abort: the owner still gets its ready pulse, flagged with err and zero data
          resp_d    = 32'h0;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          i_ready_d = !owner_q;
          d_ready_d = owner_q;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= 16'd0;
      bus_req_q   <= 1'b0;
      bus_wen_q   <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      resp_q      <= 32'h0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_wen_q   <= bus_wen_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      resp_q      <= resp_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      err_q       <= err_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mb.bus_req   = bus_req_q;
  assign mb.bus_wen   = bus_wen_q;
  assign mb.bus_addr  = bus_addr_q;
  assign mb.bus_wdata = bus_wdata_q;
  assign mb.i_rdata   = resp_q;
  assign mb.d_rdata   = resp_q;
  assign mb.i_ready   = i_ready_q;
  assign mb.d_ready   = d_ready_q;
  assign mb.err       = err_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter and sequencer sharing the single data-memory bus between instruction fetch and the MEM stage. Each master issues a held request. The block grants one master and drives the bus with registered address, write-data and byte-enables. It waits for a variable-latency acknowledge and returns read data with a one-cycle ready pulse. It sits between the fetch unit / `mem_memory` and the external memory port, and converts bus latency into pipeline stalls.

## Interface
- `TIMEOUT`, default 255: cycles in BUSY without `bus_ack` before the transaction is aborted with an error (range 1..65535).

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  fetch request; held until `i_ready`.
- `i_addr`  in  32  fetch address (read only).
- `i_rdata`  out  32  fetch read data; valid while `i_ready`.
- `i_ready`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request; held until `d_ready`.
- `d_wen`  in  4  byte enables; 0 = load, nonzero = store.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data (already lane-replicated).
- `d_rdata`  out  32  load data; valid while `d_ready`.
- `d_ready`  out  1  one-cycle data completion pulse.
- `bus_req`  out  1  bus request; held until `bus_ack`.
- `bus_wen`  out  4  bus byte enables.
- `bus_addr`  out  32  bus address.
- `bus_wdata`  out  32  bus write data.
- `bus_rdata`  in  32  bus read data; valid with `bus_ack`.
- `bus_ack`  in  1  bus completion, sampled only while `bus_req`=1.
- `err`  out  1  timeout flag; coincident with the ready pulse of the aborted transaction.

## Operation
- FSM states: IDLE, BUSY, RESP. A 1-bit `owner` register holds the grantee (0 = fetch, 1 = data).
- **IDLE**
  - If any request is present, arbitrate and latch the grantee's addr/wen/wdata into bus registers. Fetch is always latched with `wen`=0.
  - Set `bus_req`=1, clear the timeout counter, go to BUSY.
  - If no request, stay in IDLE with `bus_req`=0.
- **BUSY**
  - Bus outputs are held constant.
  - On `bus_ack`=1: capture `bus_rdata` into the response register, drop `bus_req`, go to RESP.
  - Otherwise increment the counter. When the counter equals `TIMEOUT`-1 and `bus_ack`=0: drop `bus_req`, load response 32'h0, set the error flag, go to RESP.
- **RESP**
  - Assert `owner`'s ready for exactly one cycle. Response data is driven on that master's rdata; `err` is set if timed out.
  - Next state is IDLE unconditionally.
- Masters drop or replace `req` at the edge that ends the ready cycle. A `req` still high in the following IDLE cycle is a new request.
- Requests arriving while BUSY/RESP wait; they are never lost because masters hold `req`.
- The non-owner's ready is always 0. `i_rdata`/`d_rdata` are both driven from the one response register; they are meaningful only with the matching ready.
- Arbitration when both request in IDLE is fixed priority: data wins, to keep the older pipeline instruction moving. See Configuration for the alternative.
- `i_addr`/`d_*` changes while the master is not yet granted are allowed; values are sampled only at grant.

## Timing
- Reset (`rst`=0 at an edge):
  - state = IDLE, `owner`=0, counter=0.
  - `bus_req`=0, `bus_wen`=0, `bus_addr`=0, `bus_wdata`=0.
  - `i_ready`=`d_ready`=0, `err`=0, response register 0.
  - The round-robin pointer is reset to "last = fetch".
- Reset mid-transaction aborts it: `bus_req` is low in the first cycle after reset and no ready is issued. A `bus_ack` arriving during or after reset is ignored.
- Minimum latency: req seen at edge 0 → `bus_req` high cycle 1 → `bus_ack` in cycle 1 → ready in cycle 2 → IDLE cycle 3. Back-to-back throughput is one transaction per 3 cycles.
- An ack after k BUSY cycles gives ready in cycle k+1 after grant.
- Timeout: with no ack, `bus_req` is high for exactly `TIMEOUT` cycles; `err` + ready follow in the next cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both masters request in IDLE, the master not granted last wins.
  - The pointer updates at every grant, including single-requester grants.
- Undefined: fixed data-over-fetch priority; the pointer logic is absent.

## Test plan
- Single fetch, `i_addr`=32'h0000_1000, `bus_ack` in the first BUSY cycle with `bus_rdata`=32'h2402_0005 → `bus_req` high 1 cycle, `bus_wen`=0, `i_ready` pulses in cycle 2 with `i_rdata`=32'h2402_0005, `d_ready`=0.
- Store `d_wen`=4'b0100, `d_addr`=32'h10, `d_wdata`=32'hABABABAB, ack after 4 cycles → bus outputs stable for 4 cycles, `d_ready` pulse at cycle 5, `err`=0.
- `i_req` and `d_req` both asserted together for three transactions, fixed priority → order D, D, D while `d_req` is held. With `MEM_ARB_RR_EN` → order D, I, D.
- `TIMEOUT`=8, no ack → `bus_req` high exactly 8 cycles, then `d_ready`=1, `err`=1, `d_rdata`=0. The next request completes normally with `err`=0.
- `rst`=0 in the 2nd BUSY cycle with `bus_ack`=1 in the same cycle → no ready pulse, all outputs zero the next cycle, FSM in IDLE.
- `d_req` held high past `d_ready` → a second identical transaction starts in the following IDLE cycle; no duplicate or missing ready.
